// File: rtl/fifo_buffer_param.sv
// Parametrised synchronous FIFO on a circular memory with first-word fall-through,
// occupancy count, programmable level flags, synchronous flush and sticky error flags.
module fifo_buffer_param #(
    parameter int WIDTH    = 4,
    parameter int DEPTH    = 4,
    parameter int AF_LEVEL = DEPTH - 1,
    parameter int AE_LEVEL = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           x,
    input  logic                       insert,
    input  logic                       delete,
    output logic [WIDTH-1:0]           y,
    output logic                       input_ready,
    output logic                       output_ready,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic                       overflow,
    output logic                       underflow
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_reg;
    logic [PW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             overflow_reg;
    logic             underflow_reg;
    logic             rd_en;
    logic             wr_en;

    assign input_ready  = (count_reg < FULL_CNT);
    assign output_ready = (count_reg != '0);

    // A full FIFO still takes a write when a pop frees a slot on the same edge.
    assign rd_en = delete & output_ready & ~flush;
    assign wr_en = insert & (input_ready | rd_en) & ~flush;

    assign y            = mem[rd_ptr_reg];
    assign count        = count_reg;
    assign almost_full  = (32'(count_reg) >= AF_LEVEL);
    assign almost_empty = (32'(count_reg) <= AE_LEVEL);
    assign overflow     = overflow_reg;
    assign underflow    = underflow_reg;

    // Storage is never reset; a write on the edge that sees rst is suppressed.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            mem[wr_ptr_reg] <= x;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else if (flush) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr_reg <= (wr_ptr_reg == LAST_PTR) ? '0 : wr_ptr_reg + 1'b1;
            end
            if (rd_en) begin
                rd_ptr_reg <= (rd_ptr_reg == LAST_PTR) ? '0 : rd_ptr_reg + 1'b1;
            end
            if (wr_en && !rd_en) begin
                count_reg <= count_reg + 1'b1;
            end else if (rd_en && !wr_en) begin
                count_reg <= count_reg - 1'b1;
            end
            if (insert && !wr_en) begin
                overflow_reg <= 1'b1;
            end
            if (delete && !output_ready) begin
                underflow_reg <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_fifo_buffer_param.sv
// Bench for fifo_buffer_param: three configurations share one stimulus stream and are
// compared against a queue-based reference model plus directed scenario checks.
module tb_fifo_buffer_param;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b0;
    logic       flush = 1'b0;
    logic       insert = 1'b0;
    logic       delete = 1'b0;
    logic [7:0] x = '0;

    logic [3:0] y0, y1;
    logic [7:0] y2;
    logic [2:0] c0, c1;
    logic [4:0] c2;
    logic [2:0] ir, orr, af, ae, ov, un;

    logic [7:0] ya [3];
    logic [4:0] ca [3];
    assign ya[0] = {4'b0, y0};
    assign ya[1] = {4'b0, y1};
    assign ya[2] = y2;
    assign ca[0] = {2'b0, c0};
    assign ca[1] = {2'b0, c1};
    assign ca[2] = c2;

    fifo_buffer_param #(.WIDTH(4), .DEPTH(4)) u4 (
        .clk(clk), .rst(rst), .flush(flush), .x(x[3:0]), .insert(insert), .delete(delete),
        .y(y0), .input_ready(ir[0]), .output_ready(orr[0]), .count(c0),
        .almost_full(af[0]), .almost_empty(ae[0]), .overflow(ov[0]), .underflow(un[0]));

    fifo_buffer_param #(.WIDTH(4), .DEPTH(5)) u5 (
        .clk(clk), .rst(rst), .flush(flush), .x(x[3:0]), .insert(insert), .delete(delete),
        .y(y1), .input_ready(ir[1]), .output_ready(orr[1]), .count(c1),
        .almost_full(af[1]), .almost_empty(ae[1]), .overflow(ov[1]), .underflow(un[1]));

    fifo_buffer_param #(.WIDTH(8), .DEPTH(16), .AF_LEVEL(12), .AE_LEVEL(3)) u16 (
        .clk(clk), .rst(rst), .flush(flush), .x(x), .insert(insert), .delete(delete),
        .y(y2), .input_ready(ir[2]), .output_ready(orr[2]), .count(c2),
        .almost_full(af[2]), .almost_empty(ae[2]), .overflow(ov[2]), .underflow(un[2]));

    localparam int         DEP [3] = '{4, 5, 16};
    localparam int         AFL [3] = '{3, 4, 12};
    localparam int         AEL [3] = '{1, 1, 3};
    localparam logic [7:0] MSK [3] = '{8'h0f, 8'h0f, 8'hff};

    // Reference model: one queue per instance plus sticky error bits.
    logic [7:0] mq [3][$];
    bit         mov [3];
    bit         mun [3];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic model_clear();
        for (int i = 0; i < 3; i++) begin
            mq[i].delete();
            mov[i] = 1'b0;
            mun[i] = 1'b0;
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < 3; i++) begin
            int n;
            bit rok;
            bit wok;
            n   = mq[i].size();
            rok = delete && (n > 0);
            wok = insert && ((n < DEP[i]) || rok);
            if (flush) begin
                mq[i].delete();
                mov[i] = 1'b0;
                mun[i] = 1'b0;
            end else begin
                if (insert && !wok) mov[i] = 1'b1;
                if (delete && n == 0) mun[i] = 1'b1;
                if (rok) void'(mq[i].pop_front());
                if (wok) mq[i].push_back(x & MSK[i]);
            end
        end
    endtask

    task automatic step(input bit i_ins, input bit i_del, input bit i_fl, input logic [7:0] xv);
        @(negedge clk);
        insert = i_ins;
        delete = i_del;
        flush  = i_fl;
        x      = xv;
        @(posedge clk);
        model_edge();
        #1;
        insert = 1'b0;
        delete = 1'b0;
        flush  = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        insert = 1'b0;
        delete = 1'b0;
        flush = 1'b0;
        model_clear();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (ca[i] !== 5'd0 || ir[i] !== 1'b1 || orr[i] !== 1'b0 || ae[i] !== 1'b1 ||
                af[i] !== 1'b0 || ov[i] !== 1'b0 || un[i] !== 1'b0) begin
                n_bad++;
                $display("FAIL reset[%0d]: got cnt=%0d ir=%b or=%b ae=%b af=%b ov=%b un=%b required 0 1 0 1 0 0 0",
                         i, ca[i], ir[i], orr[i], ae[i], af[i], ov[i], un[i]);
            end
        end
        $display("test_reset done");
    endtask

    logic [3:0] fill_vals [4] = '{4'b1010, 4'b0110, 4'b0001, 4'b1111};

    task automatic test_fill();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 1'b0, 1'b0, {4'b0, fill_vals[k]});
            n_cmp++;
            if (c0 !== 3'(k + 1) || y0 !== 4'b1010 || af[0] !== (k + 1 >= 3) || ir[0] !== (k + 1 < 4)) begin
                n_bad++;
                $display("FAIL fill[%0d]: got cnt=%0d y=%b af=%b ir=%b required cnt=%0d y=1010 af=%b ir=%b",
                         k, c0, y0, af[0], ir[0], k + 1, (k + 1 >= 3), (k + 1 < 4));
            end
        end
        $display("test_fill done: cnt=%0d", c0);
    endtask

    task automatic test_drain();
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (y0 !== fill_vals[k]) begin
                n_bad++;
                $display("FAIL drain_y[%0d]: got %b required %b", k, y0, fill_vals[k]);
            end
            step(1'b0, 1'b1, 1'b0, 8'h00);
            n_cmp++;
            if (c0 !== 3'(3 - k)) begin
                n_bad++;
                $display("FAIL drain_cnt[%0d]: got %0d required %0d", k, c0, 3 - k);
            end
        end
        n_cmp++;
        if (orr[0] !== 1'b0 || un[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL drain_empty: got or=%b un=%b required 0 0", orr[0], un[0]);
        end
        step(1'b0, 1'b1, 1'b0, 8'h00);
        n_cmp++;
        if (un[0] !== 1'b1 || c0 !== 3'd0) begin
            n_bad++;
            $display("FAIL underflow_set: got un=%b cnt=%0d required 1 0", un[0], c0);
        end
        step(1'b0, 1'b0, 1'b0, 8'h00);
        n_cmp++;
        if (un[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL underflow_sticky: got %b required 1", un[0]);
        end
        $display("test_drain done");
    endtask

    task automatic test_full_simul();
        logic [3:0] rest [4] = '{4'b0110, 4'b0001, 4'b1111, 4'b0011};
        do_reset();
        for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 1'b0, {4'b0, fill_vals[k]});
        step(1'b1, 1'b1, 1'b0, 8'h03);
        n_cmp++;
        if (c0 !== 3'd4 || y0 !== 4'b0110 || ov[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL full_both: got cnt=%0d y=%b ov=%b required 4 0110 0", c0, y0, ov[0]);
        end
        step(1'b1, 1'b0, 1'b0, 8'h05);
        n_cmp++;
        if (c0 !== 3'd4 || ov[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL overflow_set: got cnt=%0d ov=%b required 4 1", c0, ov[0]);
        end
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (y0 !== rest[k]) begin
                n_bad++;
                $display("FAIL full_order[%0d]: got %b required %b", k, y0, rest[k]);
            end
            step(1'b0, 1'b1, 1'b0, 8'h00);
        end
        $display("test_full_simul done");
    endtask

    task automatic test_wrap();
        int nxt = 0;
        int got = 0;
        int cyc = 0;
        bit ins;
        bit del;
        do_reset();
        while (got < 12 && cyc < 400) begin
            ins = (nxt < 12) && ir[1] && ($urandom_range(0, 2) != 0);
            del = orr[1] && ($urandom_range(0, 1) == 1);
            if (del) begin
                n_cmp++;
                if (y1 !== 4'(got)) begin
                    n_bad++;
                    $display("FAIL wrap_order[%0d]: got %0d required %0d", got, y1, got);
                end
                got++;
            end
            step(ins, del, 1'b0, 8'(nxt));
            if (ins) nxt++;
            cyc++;
        end
        n_cmp++;
        if (got != 12 || c1 !== 3'd0) begin
            n_bad++;
            $display("FAIL wrap_total: got popped=%0d cnt=%0d required 12 0", got, c1);
        end
        $display("test_wrap done: %0d words in %0d cycles", got, cyc);
    endtask

    task automatic test_flush_reset();
        do_reset();
        step(1'b0, 1'b1, 1'b0, 8'h00);
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b0, 8'(k + 7));
        n_cmp++;
        if (c0 !== 3'd3 || un[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL flush_pre: got cnt=%0d un=%b required 3 1", c0, un[0]);
        end
        step(1'b1, 1'b1, 1'b1, 8'h09);
        n_cmp++;
        if (c0 !== 3'd0 || orr[0] !== 1'b0 || un[0] !== 1'b0 || ov[0] !== 1'b0 || ae[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL flush: got cnt=%0d or=%b un=%b ov=%b ae=%b required 0 0 0 0 1",
                     c0, orr[0], un[0], ov[0], ae[0]);
        end
        step(1'b1, 1'b0, 1'b0, 8'h01);
        step(1'b1, 1'b0, 1'b0, 8'h02);
        @(negedge clk);
        #2;
        rst = 1'b1;
        model_clear();
        #1;
        n_cmp++;
        if (c0 !== 3'd0 || orr[0] !== 1'b0 || c2 !== 5'd0) begin
            n_bad++;
            $display("FAIL async_reset: got cnt=%0d or=%b cnt16=%0d required 0 0 0", c0, orr[0], c2);
        end
        @(negedge clk);
        rst = 1'b0;
        $display("test_flush_reset done");
    endtask

    task automatic test_levels();
        do_reset();
        for (int k = 1; k <= 16; k++) begin
            step(1'b1, 1'b0, 1'b0, 8'(k * 3));
            n_cmp++;
            if (c2 !== 5'(k) || ae[2] !== (k <= 3) || af[2] !== (k >= 12)) begin
                n_bad++;
                $display("FAIL level_up[%0d]: got cnt=%0d ae=%b af=%b required ae=%b af=%b",
                         k, c2, ae[2], af[2], (k <= 3), (k >= 12));
            end
        end
        for (int k = 1; k <= 16; k++) begin
            n_cmp++;
            if (y2 !== 8'(k * 3)) begin
                n_bad++;
                $display("FAIL level_y[%0d]: got %0d required %0d", k, y2, k * 3);
            end
            step(1'b0, 1'b1, 1'b0, 8'h00);
            n_cmp++;
            if (c2 !== 5'(16 - k) || ae[2] !== (16 - k <= 3) || af[2] !== (16 - k >= 12)) begin
                n_bad++;
                $display("FAIL level_down[%0d]: got cnt=%0d ae=%b af=%b required ae=%b af=%b",
                         k, c2, ae[2], af[2], (16 - k <= 3), (16 - k >= 12));
            end
        end
        $display("test_levels done");
    endtask

    task automatic test_random();
        int bias;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            bias = ((c / 40) % 2 == 0) ? 3 : 1;
            step($urandom_range(0, 3) < bias, $urandom_range(0, 3) >= bias,
                 $urandom_range(0, 59) == 0, 8'($urandom));
            for (int i = 0; i < 3; i++) begin
                int n;
                n = mq[i].size();
                n_cmp++;
                if (ca[i] !== 5'(n) || ir[i] !== (n < DEP[i]) || orr[i] !== (n > 0) ||
                    af[i] !== (n >= AFL[i]) || ae[i] !== (n <= AEL[i]) ||
                    ov[i] !== mov[i] || un[i] !== mun[i]) begin
                    n_bad++;
                    $display("FAIL rand_flags[%0d] cyc %0d: got cnt=%0d ir=%b or=%b af=%b ae=%b ov=%b un=%b required cnt=%0d ov=%b un=%b",
                             i, c, ca[i], ir[i], orr[i], af[i], ae[i], ov[i], un[i], n, mov[i], mun[i]);
                end
                if (n > 0) begin
                    n_cmp++;
                    if (ya[i] !== mq[i][0]) begin
                        n_bad++;
                        $display("FAIL rand_y[%0d] cyc %0d: got %0h required %0h", i, c, ya[i], mq[i][0]);
                    end
                end
            end
        end
        $display("test_random done");
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_full_simul();
        test_wrap();
        test_flush_reset();
        test_levels();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/fifo_buffer_param.md
Name: fifo_buffer_param

Overview:
- Parametrised synchronous FIFO; successor to the fixed 4-word x 4-bit fall-through buffer.
- Built on a circular memory with read/write pointers and an occupancy counter instead of a chain of shift stages.
- Adds:
  - configurable width and depth
  - occupancy count
  - programmable almost-full/almost-empty flags
  - synchronous flush
  - sticky overflow/underflow error flags
- Sits between a producer using insert/input_ready and a consumer using delete/output_ready.

Parameters:
- WIDTH, 4, data word width in bits (>=1).
- DEPTH, 4, number of storage entries (>=2, need not be a power of 2).
- AF_LEVEL, DEPTH-1, almost_full asserts when count >= AF_LEVEL.
- AE_LEVEL, 1, almost_empty asserts when count <= AE_LEVEL.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- flush  input  1  synchronous clear of contents, pointers and error flags.
- x  input  WIDTH  write data.
- insert  input  1  write request.
- delete  input  1  read request; pops the word currently on y.
- y  output  WIDTH  head-of-queue data, first-word fall-through.
- input_ready  output  1  high when count < DEPTH.
- output_ready  output  1  high when count > 0.
- count  output  $clog2(DEPTH+1)  number of stored words.
- almost_full  output  1  count >= AF_LEVEL.
- almost_empty  output  1  count <= AE_LEVEL.
- overflow  output  1  sticky: insert attempted while full and not accepted.
- underflow  output  1  sticky: delete attempted while empty.

Behaviour:
- Reset (rst=1, asynchronous):
  - wr_ptr = rd_ptr = 0, count = 0, overflow = underflow = 0.
  - Outputs: input_ready=1, output_ready=0, almost_empty=1, almost_full=(AF_LEVEL==0).
  - y is don't-care while empty; the bench must not check it.
  - Memory contents are not reset.
- Reset mid-operation: all stored data is discarded immediately; no partial write completes.
- Write accept: wr_en = insert & (input_ready | delete_ok).
  - delete_ok = delete & output_ready.
  - A write to a full FIFO is accepted only when a valid delete occurs in the same cycle.
- Read accept: rd_en = delete & output_ready.
- On an accepted write: mem[wr_ptr] <= x; wr_ptr <= (wr_ptr==DEPTH-1) ? 0 : wr_ptr+1.
- On an accepted read: rd_ptr wraps the same way as wr_ptr.
- count update:
  - +1 on write only.
  - -1 on read only.
  - unchanged when both or neither are accepted.
- y = mem[rd_ptr], read combinationally.
- Latency: a word written at edge N appears on y and raises output_ready after edge N, if the FIFO was empty. Fall-through latency is 1 cycle.
- Simultaneous insert and delete:
  - When empty: write accepted; read ignored and underflow set. The new word is not bypassed to y in the same cycle.
  - When full: both accepted, count stays DEPTH, overflow not set.
  - Otherwise: both accepted, count unchanged, pointers both advance.
- overflow: set on any edge with insert=1 and the write not accepted. Held until rst or flush.
- underflow: set on any edge with delete=1 and output_ready=0. Held until rst or flush.
- flush (synchronous): pointers, count and both error flags clear at the edge.
  - insert and delete in the same cycle are ignored.
  - flush has priority over every other request.
- Flags are derived from registered count, so they are glitch-free relative to clk. No flag reacts combinationally to insert or delete.
- Ordering is strictly FIFO across pointer wrap-around.

Test Plan:
1. Reset then fill, WIDTH=4, DEPTH=4: insert 1010, 0110, 0001, 1111 on 4 edges.
   - count 1,2,3,4.
   - input_ready=0 after edge 4; almost_full=1 from count 3.
   - y=1010 from the first edge onward.
2. Drain: delete for 4 cycles.
   - y sequence 1010, 0110, 0001, 1111.
   - output_ready=0 and count=0 after the 4th edge.
   - A 5th delete sets underflow=1; underflow stays 1.
3. Full plus simultaneous insert/delete: full FIFO, insert=1 with x=0011 and delete=1.
   - count stays 4, y advances to 0110, overflow stays 0.
   - Next cycle, insert alone sets overflow=1 and count stays 4.
4. Wrap-around, DEPTH=5: run 12 interleaved insert/delete operations with values 0..11.
   - Output order equals input order.
   - Pointers wrap at 4 to 0 with no lost or duplicated word.
5. Flush and reset priority:
   - Flush with count=3, insert=1, delete=1: count=0, flags cleared, output_ready=0 after the edge.
   - Assert rst asynchronously mid-cycle with count=2: count=0 and output_ready=0 immediately, before the next clk edge.
6. Parameter sweep, WIDTH=8, DEPTH=16, AF_LEVEL=12, AE_LEVEL=3:
   - almost_empty toggles between count 3 and 4.
   - almost_full toggles between count 11 and 12.
